// File: rtl/poly_io_ctrl.sv
// Polynomial I/O controller: streams N coefficients into interleaved banks, kicks the
// NTT core, then streams the result back out through a 2-entry read buffer.
module poly_io_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int N          = 256,
  parameter int NB         = 8,
  parameter int TIMEOUT    = 4095,
  localparam int SW        = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  bk_wen,
  output logic [SW-1:0]         bk_wsel,
  output logic [ADDR_WIDTH-1:0] bk_waddr,
  output logic [DATA_WIDTH-1:0] bk_wdata,
  output logic                  bk_ren,
  output logic [SW-1:0]         bk_rsel,
  output logic [ADDR_WIDTH-1:0] bk_raddr,
  input  logic [DATA_WIDTH-1:0] bk_rdata,
  output logic                  core_start,
  input  logic                  core_finish
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_K  = IW'(N - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         ld_idx_q, ld_idx_d;
  logic [IW-1:0]         rd_idx_q, rd_idx_d;
  logic [IW-1:0]         out_idx_q, out_idx_d;
  logic                  rd_all_q, rd_all_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  hs_s, pop_s, ren_s;
  logic [2:0]            occ_s;

  // Next-state, index counters and output-buffer bookkeeping.
  always_comb begin
    state_d    = state_q;
    ld_idx_d   = ld_idx_q;
    rd_idx_d   = rd_idx_q;
    out_idx_d  = out_idx_q;
    rd_all_d   = rd_all_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    mem0_d     = mem0_q;
    mem1_d     = mem1_q;
    hs_s  = (state_q == S_LOAD) && s_valid;
    pop_s = (cnt_q != 2'd0) && m_ready;
    // Occupancy net of this cycle's pop, so the stream sustains one word per cycle.
    occ_s = {1'b0, cnt_q} - {2'b00, pop_s} + {2'b00, inflight_q};
    ren_s = (state_q == S_UNLOAD) && !rd_all_q && (occ_s < 3'd2);
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_LOAD;
          ld_idx_d = {IW{1'b0}};
          err_d    = 1'b0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOAD: begin
        if (hs_s && (ld_idx_q == LAST_K)) begin
          state_d  = S_START;
        end else if (hs_s) begin
          ld_idx_d = ld_idx_q + IW'(1);
        end else begin
          ld_idx_d = ld_idx_q;
        end
      end
      S_START: begin
        state_d    = S_WAIT;
        wait_cnt_d = {CW{1'b0}};
      end
      S_WAIT: begin
        if (core_finish) begin
          state_d   = S_UNLOAD;
          rd_idx_d  = {IW{1'b0}};
          out_idx_d = {IW{1'b0}};
          rd_all_d  = 1'b0;
        end else if (wait_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      S_UNLOAD: begin
        if (ren_s && (rd_idx_q == LAST_K)) begin
          rd_all_d = 1'b1;
        end else if (ren_s) begin
          rd_idx_d = rd_idx_q + IW'(1);
        end else begin
          rd_idx_d = rd_idx_q;
        end
        if (pop_s && (out_idx_q == LAST_K)) begin
          state_d = S_DONE;
        end else if (pop_s) begin
          out_idx_d = out_idx_q + IW'(1);
        end else begin
          out_idx_d = out_idx_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    inflight_d = ren_s;
    if (inflight_q && wr_ptr_q) begin
      mem1_d = bk_rdata;
    end else if (inflight_q) begin
      mem0_d = bk_rdata;
    end else begin
      mem0_d = mem0_q;
    end
    wr_ptr_d = wr_ptr_q ^ inflight_q;
    rd_ptr_d = rd_ptr_q ^ pop_s;
    cnt_d    = cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ld_idx_q   <= {IW{1'b0}};
      rd_idx_q   <= {IW{1'b0}};
      out_idx_q  <= {IW{1'b0}};
      rd_all_q   <= 1'b0;
      wait_cnt_q <= {CW{1'b0}};
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      mem0_q     <= {DATA_WIDTH{1'b0}};
      mem1_q     <= {DATA_WIDTH{1'b0}};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      ld_idx_q   <= ld_idx_d;
      rd_idx_q   <= rd_idx_d;
      out_idx_q  <= out_idx_d;
      rd_all_q   <= rd_all_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Bank buses are zeroed when idle so nothing toggles without an enable.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign s_ready    = (state_q == S_LOAD);
  assign core_start = (state_q == S_START);
  assign bk_wen     = hs_s;
  assign bk_wsel    = hs_s ? ld_idx_q[SW-1:0] : {SW{1'b0}};
  assign bk_waddr   = hs_s ? ADDR_WIDTH'(ld_idx_q >> SW) : {ADDR_WIDTH{1'b0}};
  assign bk_wdata   = hs_s ? s_data : {DATA_WIDTH{1'b0}};
  assign bk_ren     = ren_s;
  assign bk_rsel    = ren_s ? rd_idx_q[SW-1:0] : {SW{1'b0}};
  assign bk_raddr   = ren_s ? ADDR_WIDTH'(rd_idx_q >> SW) : {ADDR_WIDTH{1'b0}};
  assign m_valid    = (cnt_q != 2'd0);
  assign m_data     = rd_ptr_q ? mem1_q : mem0_q;
  assign m_last     = m_valid && (out_idx_q == LAST_K);

endmodule

// File: tb/tb_poly_io_ctrl.sv
// Directed bench for poly_io_ctrl: bank/core models, ramp jobs with and without
// back-pressure, ignored control pulses, mid-load reset and a core timeout.
module tb_poly_io_ctrl;
  localparam int DW = 12;
  localparam int AW = 8;
  localparam int NB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, s_valid, m_ready, core_finish, run_t, s_valid_t;
  logic [DW-1:0] s_data;
  logic [DW-1:0] bk_rdata = '0;
  logic busy, done, err, s_ready, m_valid, m_last, bk_wen, bk_ren, core_start;
  logic [DW-1:0] m_data, bk_wdata;
  logic [2:0] bk_wsel, bk_rsel;
  logic [AW-1:0] bk_waddr, bk_raddr;
  logic busy_t, done_t, err_t, s_ready_t, m_valid_t, m_last_t, bk_wen_t, bk_ren_t, core_start_t;
  logic [DW-1:0] m_data_t, bk_wdata_t;
  logic [2:0] bk_wsel_t, bk_rsel_t;
  logic [AW-1:0] bk_waddr_t, bk_raddr_t;

  poly_io_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .bk_wen(bk_wen), .bk_wsel(bk_wsel), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata),
    .bk_ren(bk_ren), .bk_rsel(bk_rsel), .bk_raddr(bk_raddr), .bk_rdata(bk_rdata),
    .core_start(core_start), .core_finish(core_finish)
  );

  poly_io_ctrl #(.TIMEOUT(15)) dut_t (
    .clk(clk), .rst(rst), .run(run_t), .busy(busy_t), .done(done_t), .err(err_t),
    .s_valid(s_valid_t), .s_ready(s_ready_t), .s_data(s_data),
    .m_valid(m_valid_t), .m_ready(m_ready), .m_data(m_data_t), .m_last(m_last_t),
    .bk_wen(bk_wen_t), .bk_wsel(bk_wsel_t), .bk_waddr(bk_waddr_t), .bk_wdata(bk_wdata_t),
    .bk_ren(bk_ren_t), .bk_rsel(bk_rsel_t), .bk_raddr(bk_raddr_t), .bk_rdata(bk_rdata),
    .core_start(core_start_t), .core_finish(1'b0)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bank model: write-through memory with one-cycle registered read.
  logic [DW-1:0] mem [NB][256];
  always @(posedge clk) begin
    if (bk_wen) mem[bk_wsel][bk_waddr] <= bk_wdata;
    if (bk_ren) bk_rdata <= mem[bk_rsel][bk_raddr];
  end

  // Core model: finish pulse 20 cycles after start, plus an injectable stray pulse.
  int cd = 0;
  logic fin_m = 1'b0;
  logic fin_inj;
  assign core_finish = fin_m | fin_inj;
  always @(posedge clk) begin
    fin_m <= 1'b0;
    if (core_start) cd <= 19;
    else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) fin_m <= 1'b1;
    end
  end

  logic stall_en = 1'b0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Protocol monitor for the main instance.
  int cyc = 0, wr_k = 0, rd_k = 0, exp_out = 0, n_starts = 0, n_done = 0;
  int last_wr_cyc = -10, last_pop_cyc = -10, issued = 0, popped = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      wr_k <= 0; rd_k <= 0; exp_out <= 0; n_starts <= 0;
      issued <= 0; popped <= 0; prev_stall <= 1'b0;
    end else begin
      if (!busy) check_val("idle_quiet", {bk_wen, bk_ren, core_start, done, m_valid}, 5'd0);
      if (!busy && run) begin
        wr_k <= 0; rd_k <= 0; exp_out <= 0; n_starts <= 0;
      end
      if (bk_wen) begin
        check_val("wsel", bk_wsel, wr_k % 8);
        check_val("waddr", bk_waddr, wr_k / 8);
        check_val("wdata", bk_wdata, wr_k);
        wr_k <= wr_k + 1;
        last_wr_cyc <= cyc;
      end
      if (core_start) begin
        check_val("start_after_last_wr", cyc - last_wr_cyc, 1);
        check_val("writes_before_start", wr_k, 256);
        n_starts <= n_starts + 1;
      end
      if (prev_stall) begin
        check_val("stall_valid", m_valid, 1);
        check_val("stall_data", m_data, prev_data);
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      if (m_valid && m_ready) begin
        check_val("m_data", m_data, exp_out);
        check_val("m_last", m_last, exp_out == 255);
        exp_out <= exp_out + 1;
        last_pop_cyc <= cyc;
      end
      if (bk_ren) begin
        check_val("rsel", bk_rsel, rd_k % 8);
        check_val("raddr", bk_raddr, rd_k / 8);
        check_val("outstanding", (issued - popped - ((m_valid && m_ready) ? 1 : 0) + 1) <= 2, 1);
        rd_k <= rd_k + 1;
      end
      issued <= issued + (bk_ren ? 1 : 0);
      popped <= popped + ((m_valid && m_ready) ? 1 : 0);
      if (done) begin
        check_val("done_after_last_pop", cyc - last_pop_cyc, 1);
        check_val("outputs_before_done", exp_out, 256);
        n_done <= n_done + 1;
      end
    end
  end

  logic ren_t_seen = 1'b0, done_t_seen = 1'b0;
  always @(negedge clk) begin
    if (bk_ren_t) ren_t_seen <= 1'b1;
    if (done_t) done_t_seen <= 1'b1;
  end

  task automatic pulse_run;
    @(posedge clk); #1 run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
  endtask

  task automatic load(input int n, input bit inject);
    int k = 0;
    int t = 0;
    logic hs;
    s_valid = 1'b1;
    s_data = '0;
    while (k < n && t < 1000) begin
      @(negedge clk);
      t++;
      hs = s_ready;
      @(posedge clk); #1;
      if (hs) begin
        k++;
        s_data = DW'(k);
      end
      run = inject && (k == 50);
      fin_inj = inject && (k == 60);
    end
    s_valid = 1'b0;
    run = 1'b0;
    fin_inj = 1'b0;
    check_val("load_count", k, n);
  endtask

  task automatic finish_job(input bit inject);
    int t = 0;
    int base = n_done;
    bit pulsed = 0;
    while (n_done == base && t < 3000) begin
      @(negedge clk);
      t++;
      run = inject && !pulsed && (exp_out == 100);
      if (run) pulsed = 1;
    end
    run = 1'b0;
    check_val("done_seen", n_done, base + 1);
    @(negedge clk);
    check_val("job_starts", n_starts, 1);
    check_val("job_outputs", exp_out, 256);
    check_val("busy_after_done", busy, 0);
    check_val("err_main", err, 0);
  endtask

  initial begin
    int t;
    int n;
    rst = 1'b1; run = 1'b0; s_valid = 1'b1; s_data = 12'hABC; fin_inj = 1'b0;
    run_t = 1'b0; s_valid_t = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctrl", {busy, done, err, s_ready, m_valid, m_last, bk_wen, bk_ren, core_start}, 9'd0);
    check_val("rst_wr_bus", {bk_wsel, bk_waddr, bk_wdata}, 0);
    check_val("rst_rd_bus", {bk_rsel, bk_raddr, m_data}, 0);
    @(posedge clk); #1 rst = 1'b0; s_valid = 1'b0; s_data = '0;

    // Ramp job, full-rate unload.
    pulse_run; load(256, 0); finish_job(0);
    // Random back-pressure on the unload stream.
    stall_en = 1'b1;
    pulse_run; load(256, 0); finish_job(0);
    // Stray run and finish pulses must be ignored.
    pulse_run; load(256, 1); finish_job(1);
    stall_en = 1'b0;

    // Reset after 100 handshakes, then a fresh job from k=0.
    pulse_run; load(100, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("abort_idle", {busy, s_ready, bk_wen, m_valid}, 4'd0);
    pulse_run; load(256, 0); finish_job(0);

    // Timeout instance: no finish ever arrives.
    s_valid_t = 1'b1;
    @(posedge clk); #1 run_t = 1'b1;
    @(posedge clk); #1 run_t = 1'b0;
    t = 0;
    while (!core_start_t && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_val("to_start_seen", core_start_t, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_t && n < 100);
    check_val("to_wait_cycles", n, 16);
    check_val("to_err", err_t, 1);
    check_val("to_no_ren", ren_t_seen, 0);
    check_val("to_no_done", done_t_seen, 0);
    repeat (3) @(negedge clk);
    check_val("err_sticky", err_t, 1);
    s_valid_t = 1'b0;
    @(posedge clk); #1 run_t = 1'b1;
    @(posedge clk); #1 run_t = 1'b0;
    @(negedge clk);
    check_val("err_cleared", err_t, 0);
    check_val("busy_t_after_run", busy_t, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
